// File: rtl/mel_frame_ring_if.sv
// mel_frame_ring_if
//   Streaming bus between the mel filter, the frame ring and the binarizer.
//   Input side : in_valid / in_data   (one mel value per pulse, no backpressure)
//   Output side: out_valid / out_ready handshake carrying out_sum, out_flux and
//                out_last (last element of a frame).
//   slave  : view used by mel_frame_ring
//   master : view used by the producer/consumer environment
interface mel_frame_ring_if #(
    parameter int unsigned BIT_WIDTH = 16
);
    logic                 in_valid;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 out_ready;
    logic                 out_valid;
    logic [BIT_WIDTH-1:0] out_sum;
    logic [BIT_WIDTH-1:0] out_flux;
    logic                 out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_sum,
        output out_flux,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_sum,
        input  out_flux,
        input  out_last
    );
endinterface

// File: rtl/mel_frame_ring.sv
// mel_frame_ring
//   Keeps the last N_BANKS mel frames. For every new frame it streams, element
//   by element, the saturated sum and the absolute difference between that
//   frame and the frame lag_q frames earlier. Frames that would overwrite live
//   history are dropped and reported through the sticky overflow flag.
//   N_BANKS must be at least 3.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : synchronous enable; low clears all control state
//   cfg_lag    : frame lag, sampled while en=0 (clamped to 1..N_BANKS-2)
//   bus        : mel_frame_ring_if slave (in_valid/in_data, out_* handshake)
//   overflow   : sticky frame-drop flag
module mel_frame_ring #(
    parameter int unsigned N_MEL     = 32,
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned N_BANKS   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [$clog2(N_BANKS)-1:0] cfg_lag,
    mel_frame_ring_if.slave            bus,
    output logic                       overflow
);
    localparam int unsigned LW = $clog2(N_BANKS);
    localparam int unsigned IW = $clog2(N_MEL);
    localparam int unsigned PW = LW + 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(N_MEL - 1);
    localparam logic [LW-1:0] LAST_BANK = LW'(N_BANKS - 1);
    localparam logic [LW-1:0] MAX_LAG   = LW'(N_BANKS - 2);
    localparam logic [PW-1:0] PEND_CAP  = PW'(N_BANKS - 2);

    typedef enum logic [0:0] {R_IDLE, R_READ} rstate_e;

    function automatic logic [LW-1:0] bank_inc(input logic [LW-1:0] b);
        return (b == LAST_BANK) ? '0 : b + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [BIT_WIDTH-1:0] mem_q [N_BANKS][N_MEL];
    logic [BIT_WIDTH-1:0] cur_q;
    logic [BIT_WIDTH-1:0] past_q;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [LW-1:0] lag_q;
    logic [LW-1:0] lag_clamp;
    logic [IW-1:0] wr_idx_q,   wr_idx_d;
    logic [LW-1:0] wr_bank_q,  wr_bank_d;
    logic [LW-1:0] hist_cnt_q, hist_cnt_d;
    logic [PW-1:0] pend_q,     pend_d;
    logic [PW-1:0] pend_dec;
    logic          ovf_q,      ovf_d;

    rstate_e       rstate_q;
    logic [IW-1:0] rd_idx_q;
    logic [LW-1:0] rd_bank_q;
    logic [LW-1:0] past_bank;
    logic          rd_vld_q;
    logic          rd_last_q;

    logic                 out_valid_q;
    logic [BIT_WIDTH-1:0] out_sum_q;
    logic [BIT_WIDTH-1:0] out_flux_q;
    logic                 out_last_q;

    logic wr_fire;
    logic wr_done;
    logic hist_adv;
    logic issue;
    logic rd_last;

    // ------------------------------------------------------------------
    // Lag clamp
    // ------------------------------------------------------------------
    always_comb begin
        lag_clamp = cfg_lag;
        if (cfg_lag == '0) begin
            lag_clamp = LW'(1);
        end else if (cfg_lag > MAX_LAG) begin
            lag_clamp = MAX_LAG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lag_q <= LW'(1);
        end else if (!en) begin
            lag_q <= lag_clamp;
        end
    end

    // ------------------------------------------------------------------
    // Handshake / event decode
    // ------------------------------------------------------------------
    assign wr_fire  = en && bus.in_valid;
    assign wr_done  = wr_fire && (wr_idx_q == LAST_IDX);
    assign hist_adv = wr_done && (hist_cnt_q < lag_q);
    assign issue    = en && (rstate_q == R_READ) && !rd_vld_q &&
                      (!out_valid_q || bus.out_ready);
    assign rd_last  = issue && (rd_idx_q == LAST_IDX);

    assign past_bank = (rd_bank_q >= lag_q) ? (rd_bank_q - lag_q)
                     : LW'({1'b0, rd_bank_q} + PW'(N_BANKS) - {1'b0, lag_q});

    // ------------------------------------------------------------------
    // Write side: index, bank, history count, pending frames, overflow
    // ------------------------------------------------------------------
    always_comb begin
        pend_dec   = pend_q - PW'(rd_last);
        wr_idx_d   = wr_idx_q;
        wr_bank_d  = wr_bank_q;
        hist_cnt_d = hist_cnt_q;
        pend_d     = pend_dec;
        ovf_d      = ovf_q;

        if (wr_fire) begin
            wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + 1'b1;
        end

        if (wr_done) begin
            if (hist_cnt_q < lag_q) begin
                hist_cnt_d = hist_cnt_q + 1'b1;
                wr_bank_d  = bank_inc(wr_bank_q);
            end else if (pend_dec <= PEND_CAP - {1'b0, lag_q}) begin
                pend_d    = pend_dec + 1'b1;
                wr_bank_d = bank_inc(wr_bank_q);
            end else begin
                // Bank is reused by the next frame.
                ovf_d = 1'b1;
            end
        end

        if (!en) begin
            wr_idx_d   = '0;
            wr_bank_d  = '0;
            hist_cnt_d = '0;
            pend_d     = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q   <= '0;
            wr_bank_q  <= '0;
            hist_cnt_q <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            wr_bank_q  <= wr_bank_d;
            hist_cnt_q <= hist_cnt_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory: one write port, two synchronous read ports
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_idx_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            cur_q  <= mem_q[rd_bank_q][rd_idx_q];
            past_q <= mem_q[past_bank][rd_idx_q];
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic on the read stage
    // ------------------------------------------------------------------
    logic [BIT_WIDTH:0]   sum_w;
    logic [BIT_WIDTH:0]   diff_w;
    logic [BIT_WIDTH-1:0] sum_sat;
    logic [BIT_WIDTH-1:0] flux_abs;

    always_comb begin
        sum_w    = {1'b0, cur_q} + {1'b0, past_q};
        diff_w   = {1'b0, cur_q} - {1'b0, past_q};
        sum_sat  = sum_w[BIT_WIDTH] ? '1 : sum_w[BIT_WIDTH-1:0];
        flux_abs = diff_w[BIT_WIDTH] ? (~diff_w[BIT_WIDTH-1:0] + 1'b1)
                                     : diff_w[BIT_WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Read FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q    <= R_IDLE;
            rd_idx_q    <= '0;
            rd_bank_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_flux_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (!en) begin
            rstate_q    <= R_IDLE;
            rd_idx_q    <= '0;
            rd_bank_q   <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_flux_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            rd_vld_q  <= issue;
            rd_last_q <= rd_last;

            // rd_bank tracks wr_bank through the history frames so the first
            // accepted frame is read from the bank it was written to.
            if (hist_adv) begin
                rd_bank_q <= bank_inc(rd_bank_q);
            end

            case (rstate_q)
                R_IDLE: begin
                    if (pend_q != '0) begin
                        rstate_q <= R_READ;
                    end
                end
                R_READ: begin
                    if (issue) begin
                        if (rd_idx_q == LAST_IDX) begin
                            rd_idx_q  <= '0;
                            rd_bank_q <= bank_inc(rd_bank_q);
                            rstate_q  <= R_IDLE;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase

            if (rd_vld_q) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= sum_sat;
                out_flux_q  <= flux_abs;
                out_last_q  <= rd_last_q;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_flux  = out_flux_q;
    assign bus.out_last  = out_last_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_mel_frame_ring.sv
// tb_mel_frame_ring
//   Directed bench for mel_frame_ring (N_MEL=32, BIT_WIDTH=16, N_BANKS=4).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge. Accepted output elements are collected into queues
//   and compared against hand-computed frame values.
module tb_mel_frame_ring;
    localparam int unsigned N_MEL = 32;
    localparam int unsigned BW    = 16;
    localparam int unsigned NB    = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       en      = 1'b0;
    logic [1:0] cfg_lag = 2'd1;
    logic       overflow;
    logic       bp_done = 1'b0;

    mel_frame_ring_if #(.BIT_WIDTH(BW)) bus();

    mel_frame_ring #(
        .N_MEL    (N_MEL),
        .BIT_WIDTH(BW),
        .N_BANKS  (NB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .cfg_lag (cfg_lag),
        .bus     (bus),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int q_sum[$];
    int q_flux[$];
    int q_last[$];
    int q_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Collector and stall-stability monitor.
    logic        held = 1'b0;
    logic [15:0] h_sum;
    logic [15:0] h_flux;
    logic        h_last;

    always @(negedge clk) begin
        if (en && held) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_sum",   bus.out_sum,   h_sum);
            chk("hold_flux",  bus.out_flux,  h_flux);
            chk("hold_last",  bus.out_last,  h_last);
        end
        held   = en && bus.out_valid && !bus.out_ready;
        h_sum  = bus.out_sum;
        h_flux = bus.out_flux;
        h_last = bus.out_last;
        if (en && bus.out_valid && bus.out_ready) begin
            q_sum.push_back(int'(bus.out_sum));
            q_flux.push_back(int'(bus.out_flux));
            q_last.push_back(int'(bus.out_last));
            q_t.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q_sum.delete();
        q_flux.delete();
        q_last.delete();
        q_t.delete();
    endtask

    task automatic send_frame(input int base, input int step);
        for (int i = 0; i < int'(N_MEL); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(base + step * i);
            tick(1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic restart(input logic [1:0] lag);
        en      = 1'b0;
        cfg_lag = lag;
        tick(2);
        clear_q();
        en = 1'b1;
    endtask

    task automatic wait_n(input string tag, input int n);
        int c = 0;
        while (q_sum.size() < n && c < 3000) begin
            tick(1);
            c++;
        end
        chk({tag, "_count"}, q_sum.size(), n);
    endtask

    task automatic check_frame(input string tag, input int start,
                               input int cb, input int cs, input int pb, input int ps);
        for (int i = 0; i < int'(N_MEL); i++) begin
            int cur  = cb + cs * i;
            int past = pb + ps * i;
            int s    = (cur + past > 65535) ? 65535 : cur + past;
            int f    = (cur > past) ? cur - past : past - cur;
            if (start + i >= q_sum.size()) begin
                chk($sformatf("%s_missing", tag), q_sum.size(), start + i + 1);
                return;
            end
            chk($sformatf("%s_sum[%0d]",  tag, i), q_sum[start+i],  s);
            chk($sformatf("%s_flux[%0d]", tag, i), q_flux[start+i], f);
            chk($sformatf("%s_last[%0d]", tag, i), q_last[start+i], (i == int'(N_MEL) - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_sum",   bus.out_sum,   0);
        chk("rst_flux",  bus.out_flux,  0);
        chk("rst_last",  bus.out_last,  0);
        chk("rst_ovf",   overflow,      0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Basic lag 1
        bus.out_ready = 1'b1;
        restart(2'd1);
        send_frame(100, 0);
        tick(10);
        chk("basic_noout", q_sum.size(), 0);
        send_frame(300, 0);
        wait_n("basic", 32);
        check_frame("basic", 0, 300, 0, 100, 0);
        nb = 0;
        for (int k = 1; k < q_t.size(); k++) begin
            if (q_t[k] - q_t[k-1] != 2) nb++;
        end
        chk("basic_spacing", nb, 0);
        tick(20);
        chk("basic_extra", q_sum.size(), 32);

        // Saturation, both orders
        restart(2'd1);
        send_frame(16'hFFF0, 0);
        send_frame(16'h0020, 0);
        wait_n("sat", 32);
        check_frame("sat", 0, 16'h0020, 0, 16'hFFF0, 0);
        send_frame(16'hFFF0, 0);
        wait_n("satrev", 64);
        check_frame("satrev", 32, 16'hFFF0, 0, 16'h0020, 0);

        // Lag 2
        restart(2'd2);
        send_frame(10, 0);
        send_frame(20, 0);
        tick(20);
        chk("lag2_noout", q_sum.size(), 0);
        send_frame(50, 0);
        wait_n("lag2", 32);
        check_frame("lag2", 0, 50, 0, 10, 0);

        // cfg_lag=0 clamps to 1
        restart(2'd0);
        send_frame(10, 0);
        send_frame(20, 0);
        wait_n("lag0", 32);
        check_frame("lag0", 0, 20, 0, 10, 0);

        // cfg_lag=3 clamps to 2
        restart(2'd3);
        send_frame(10, 0);
        send_frame(20, 0);
        tick(20);
        chk("lag3_noout", q_sum.size(), 0);
        send_frame(50, 0);
        wait_n("lag3", 32);
        check_frame("lag3", 0, 50, 0, 10, 0);

        // Overflow: F3 dropped, F4 pairs with F2
        bus.out_ready = 1'b0;
        restart(2'd1);
        send_frame(1000, 0);
        send_frame(2000, 0);
        send_frame(4000, 0);
        chk("ovf_before", overflow, 0);
        send_frame(8000, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_stall_valid", bus.out_valid, 1);
        chk("ovf_stall_q", q_sum.size(), 0);
        bus.out_ready = 1'b1;
        wait_n("ovf_drain", 64);
        check_frame("ovf_f1", 0, 2000, 0, 1000, 0);
        check_frame("ovf_f2", 32, 4000, 0, 2000, 0);
        send_frame(5000, 0);
        wait_n("ovf_f4", 96);
        check_frame("ovf_f4", 64, 5000, 0, 4000, 0);
        chk("ovf_sticky", overflow, 1);

        // Random backpressure with ramped frames
        restart(2'd1);
        bp_done = 1'b0;
        fork
            begin
                send_frame(0, 3);
                send_frame(1000, 5);
                send_frame(50, 100);
                wait_n("bp", 64);
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        bus.out_ready = 1'b1;
        check_frame("bp1", 0, 1000, 5, 0, 3);
        check_frame("bp2", 32, 50, 100, 1000, 5);
        tick(20);
        chk("bp_extra", q_sum.size(), 64);

        // en deassert mid-read
        bus.out_ready = 1'b0;
        restart(2'd1);
        send_frame(100, 0);
        send_frame(300, 0);
        send_frame(500, 0);
        send_frame(700, 0);
        tick(2);
        chk("en_pre_valid", bus.out_valid, 1);
        chk("en_pre_ovf",   overflow,      1);
        en = 1'b0;
        tick(1);
        chk("en_valid", bus.out_valid, 0);
        chk("en_ovf",   overflow,      0);
        chk("en_sum",   bus.out_sum,   0);
        chk("en_flux",  bus.out_flux,  0);
        chk("en_last",  bus.out_last,  0);
        cfg_lag       = 2'd1;
        bus.out_ready = 1'b1;
        tick(1);
        clear_q();
        en = 1'b1;
        send_frame(700, 0);
        tick(30);
        chk("reen_noout", q_sum.size(), 0);
        send_frame(800, 0);
        wait_n("reen", 32);
        check_frame("reen", 0, 800, 0, 700, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
